// File: rtl/qupls_alu_issue_ctrl.sv
// Single-lane ALU issue controller: round-robin grant, latency-class sequencing, writeback slot.
// Optional macro QUPLS_ALU_DIV_TIMEOUT_EN adds a DIV_TMO-cycle divide watchdog.
module qupls_alu_issue_ctrl #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TAGW    = 6,
  parameter int unsigned WID     = 64,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_TMO = 255
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [NREQ-1:0]                            req_i,
  input  logic [2*NREQ-1:0]                          req_cls_i,
  input  logic [TAGW*NREQ-1:0]                       req_tag_i,
  output logic [NREQ-1:0]                            gnt_o,
  output logic                                       alu_ld_o,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] alu_sel_o,
  input  logic [WID-1:0]                             alu_o_i,
  input  logic                                       alu_div_done_i,
  input  logic                                       alu_dbz_i,
  output logic                                       wb_v_o,
  output logic [TAGW-1:0]                            wb_tag_o,
  output logic [WID-1:0]                             wb_res_o,
  output logic [1:0]                                 wb_exc_o,
  input  logic                                       wb_stall_i,
  output logic                                       busy_o
);

  localparam int unsigned SELW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_LIM0 = (MUL_LAT > DIV_TMO) ? MUL_LAT : DIV_TMO;
  localparam int unsigned CNT_LIM  = (CNT_LIM0 < 2) ? 2 : CNT_LIM0;
  localparam int unsigned CNTW     = $clog2(CNT_LIM + 1);

  typedef enum logic [1:0] {IDLE, EXEC1, MULW, DIVW} state_e;

  state_e            state_q, state_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              wb_v_q, wb_v_d;
  logic [TAGW-1:0]   wb_tag_q, wb_tag_d;
  logic [WID-1:0]    wb_res_q, wb_res_d;
  logic [1:0]        wb_exc_q, wb_exc_d;

  logic              found;
  logic [SELW-1:0]   win;
  logic [1:0]        win_cls;
  logic [TAGW-1:0]   win_tag;
  logic              cap;
  logic [WID-1:0]    cap_res;
  logic [1:0]        cap_exc;

  function automatic int wrap_idx(input int a);
    return (a >= int'(NREQ)) ? a - int'(NREQ) : a;
  endfunction

  // Round-robin search starting at the pointer; first asserted request wins.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    win_cls = 2'b00;
    win_tag = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      for (int k = 0; k < int'(NREQ); k++) begin
        if (!found && req_i[k] && (wrap_idx(int'(ptr_q) + i) == k)) begin
          found = 1'b1;
          win   = SELW'(k);
        end
      end
    end
    for (int k = 0; k < int'(NREQ); k++) begin
      if (win == SELW'(k)) begin
        win_cls = req_cls_i[2*k +: 2];
        win_tag = req_tag_i[k*TAGW +: TAGW];
      end
    end
  end

  // Sequencer next state, grant strobes and writeback slot update.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    tag_d    = tag_q;
    cnt_d    = cnt_q;
    gnt_o    = '0;
    alu_ld_o = 1'b0;
    cap      = 1'b0;
    cap_res  = '0;
    cap_exc  = 2'b00;

    case (state_q)
      IDLE: begin
        if (!rst_i && found && (!wb_v_q || !wb_stall_i)) begin
          gnt_o[win] = 1'b1;
          alu_ld_o   = 1'b1;
          sel_d      = win;
          tag_d      = win_tag;
          cnt_d      = '0;
          ptr_d      = (win == SELW'(NREQ - 1)) ? '0 : win + SELW'(1);
          case (win_cls)
            2'b01:   state_d = MULW;
            2'b10:   state_d = DIVW;
            default: state_d = EXEC1;
          endcase
        end
      end
      EXEC1: begin
        cap     = 1'b1;
        cap_res = alu_o_i;
        state_d = IDLE;
      end
      MULW: begin
        if (cnt_q == CNTW'(MUL_LAT - 1)) begin
          cap     = 1'b1;
          cap_res = alu_o_i;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      DIVW: begin
        // cnt_q==0 is the first cycle after load: a stale done from the 2x domain is ignored
        if ((cnt_q != '0) && alu_div_done_i) begin
          cap     = 1'b1;
          cap_res = alu_o_i;
          cap_exc = alu_dbz_i ? 2'b01 : 2'b00;
          state_d = IDLE;
`ifdef QUPLS_ALU_DIV_TIMEOUT_EN
        end else if (cnt_q == CNTW'(DIV_TMO - 1)) begin
          cap     = 1'b1;
          cap_res = '0;
          cap_exc = 2'b10;
          state_d = IDLE;
`endif
        end else if (cnt_q != CNTW'(CNT_LIM)) begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    wb_v_d   = wb_v_q;
    wb_tag_d = wb_tag_q;
    wb_res_d = wb_res_q;
    wb_exc_d = wb_exc_q;
    if (cap) begin
      wb_v_d   = 1'b1;
      wb_tag_d = tag_q;
      wb_res_d = cap_res;
      wb_exc_d = cap_exc;
    end else if (wb_v_q && !wb_stall_i) begin
      wb_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      tag_q    <= '0;
      cnt_q    <= '0;
      wb_v_q   <= 1'b0;
      wb_tag_q <= '0;
      wb_res_q <= '0;
      wb_exc_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      tag_q    <= tag_d;
      cnt_q    <= cnt_d;
      wb_v_q   <= wb_v_d;
      wb_tag_q <= wb_tag_d;
      wb_res_q <= wb_res_d;
      wb_exc_q <= wb_exc_d;
    end
  end

  assign alu_sel_o = sel_q;
  assign wb_v_o    = wb_v_q;
  assign wb_tag_o  = wb_tag_q;
  assign wb_res_o  = wb_res_q;
  assign wb_exc_o  = wb_exc_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_qupls_alu_issue_ctrl.sv
// Directed bench for qupls_alu_issue_ctrl; the divide watchdog scenario runs when
// QUPLS_ALU_DIV_TIMEOUT_EN is defined.
module tb_qupls_alu_issue_ctrl;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned TAGW    = 6;
  localparam int unsigned WID     = 64;
  localparam int unsigned MUL_LAT = 4;
`ifdef QUPLS_ALU_DIV_TIMEOUT_EN
  localparam int unsigned DIV_TMO = 20;
`else
  localparam int unsigned DIV_TMO = 255;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    req_cls;
  logic [TAGW*NREQ-1:0] req_tag;
  logic [NREQ-1:0]      gnt;
  logic                 alu_ld;
  logic [1:0]           alu_sel;
  logic [WID-1:0]       alu_o;
  logic                 div_done;
  logic                 dbz;
  logic                 wb_v;
  logic [TAGW-1:0]      wb_tag;
  logic [WID-1:0]       wb_res;
  logic [1:0]           wb_exc;
  logic                 wb_stall;
  logic                 busy;

  logic                 alu_fix_en;
  logic [WID-1:0]       alu_fix;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // ALU model: either a fixed value or a value identifying the selected operand
  assign alu_o = alu_fix_en ? alu_fix : (64'hCAFE_0000 | 64'(alu_sel));

  qupls_alu_issue_ctrl #(
    .NREQ(NREQ), .TAGW(TAGW), .WID(WID), .MUL_LAT(MUL_LAT), .DIV_TMO(DIV_TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_cls_i(req_cls), .req_tag_i(req_tag),
    .gnt_o(gnt), .alu_ld_o(alu_ld), .alu_sel_o(alu_sel), .alu_o_i(alu_o),
    .alu_div_done_i(div_done), .alu_dbz_i(dbz), .wb_v_o(wb_v), .wb_tag_o(wb_tag),
    .wb_res_o(wb_res), .wb_exc_o(wb_exc), .wb_stall_i(wb_stall), .busy_o(busy)
  );

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({gnt, alu_ld} !== 5'b0) begin errors++; $display("FAIL rst_gnt got=%b exp=00000", {gnt, alu_ld}); end
    checks++; if ({wb_v, wb_tag, wb_exc, busy, alu_sel} !== 12'h000) begin errors++; $display("FAIL rst_outs got=%h exp=000", {wb_v, wb_tag, wb_exc, busy, alu_sel}); end
    checks++; if (wb_res !== 64'h0) begin errors++; $display("FAIL rst_res got=%h exp=0", wb_res); end
    @(negedge clk); rst = 1'b0; req = 4'b0000; #1;
    checks++; if ({gnt, busy} !== 5'b0) begin errors++; $display("FAIL rst_idle got=%b exp=00000", {gnt, busy}); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g;
    int k, prev;
    req_cls = 8'b11_00_00_00; alu_fix_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      k = i % 4; prev = (k + 3) % 4;
      exp_g = 4'b0001 << k;
      @(negedge clk); req = 4'b1111; #1;
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rot_gnt i=%0d got=%b exp=%b", i, gnt, exp_g); end
      checks++; if (alu_ld !== 1'b1) begin errors++; $display("FAIL rot_ld i=%0d got=%b exp=1", i, alu_ld); end
      if (i > 0) begin
        checks++; if (wb_v !== 1'b1) begin errors++; $display("FAIL rot_wbv i=%0d got=%b exp=1", i, wb_v); end
        checks++; if (wb_tag !== 6'(16 + prev)) begin errors++; $display("FAIL rot_tag i=%0d got=%h exp=%h", i, wb_tag, 6'(16 + prev)); end
        checks++; if (wb_res !== (64'hCAFE_0000 | 64'(prev))) begin errors++; $display("FAIL rot_res i=%0d got=%h exp=%h", i, wb_res, 64'hCAFE_0000 | 64'(prev)); end
      end else begin
        checks++; if (wb_v !== 1'b0) begin errors++; $display("FAIL rot_wbv0 got=%b exp=0", wb_v); end
      end
      @(negedge clk); if (i == 4) req = 4'b0000; #1;
      checks++; if ({gnt, busy} !== 5'b00001) begin errors++; $display("FAIL rot_exec i=%0d got=%b exp=00001", i, {gnt, busy}); end
      checks++; if (alu_sel !== 2'(k)) begin errors++; $display("FAIL rot_sel i=%0d got=%0d exp=%0d", i, alu_sel, k); end
    end
    @(negedge clk); #1;
    checks++; if ({wb_v, wb_tag} !== {1'b1, 6'h10}) begin errors++; $display("FAIL rot_last got=%h exp=%h", {wb_v, wb_tag}, {1'b1, 6'h10}); end
    checks++; if (wb_res !== 64'hCAFE_0000) begin errors++; $display("FAIL rot_lastres got=%h exp=cafe0000", wb_res); end
  endtask

  task automatic test_mul();
    @(negedge clk);
    req = 4'b0101; req_cls[5:4] = 2'b01; req_cls[1:0] = 2'b00; req_tag[17:12] = 6'h15;
    alu_fix_en = 1'b1; alu_fix = 64'h1234; #1;
    checks++; if ({gnt, alu_ld, wb_v} !== 6'b0100_1_0) begin errors++; $display("FAIL mul_gnt got=%b exp=010010", {gnt, alu_ld, wb_v}); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); #1;
      checks++; if ({gnt, wb_v, busy} !== 6'b0000_0_1) begin errors++; $display("FAIL mul_wait t+%0d got=%b exp=000001", i, {gnt, wb_v, busy}); end
    end
    @(negedge clk); #1;
    checks++; if ({wb_v, wb_tag, wb_exc} !== {1'b1, 6'h15, 2'b00}) begin errors++; $display("FAIL mul_wb got=%h exp=%h", {wb_v, wb_tag, wb_exc}, {1'b1, 6'h15, 2'b00}); end
    checks++; if (wb_res !== 64'h1234) begin errors++; $display("FAIL mul_res got=%h exp=1234", wb_res); end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mul_next_gnt got=%b exp=0001", gnt); end
    @(negedge clk); req = 4'b0000; #1;
    checks++; if (wb_v !== 1'b0) begin errors++; $display("FAIL mul_clr got=%b exp=0", wb_v); end
    @(negedge clk); #1;
    checks++; if ({wb_v, wb_tag} !== {1'b1, 6'h10}) begin errors++; $display("FAIL mul_b2b got=%h exp=%h", {wb_v, wb_tag}, {1'b1, 6'h10}); end
  endtask

  task automatic test_div_stale();
    @(negedge clk);
    req = 4'b1000; req_cls[7:6] = 2'b10; req_tag[23:18] = 6'h23;
    div_done = 1'b1; alu_fix = 64'hD1D0; #1;
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL div_gnt got=%b exp=1000", gnt); end
    @(negedge clk); req = 4'b0000; #1;
    checks++; if ({gnt, wb_v, busy} !== 6'b000001) begin errors++; $display("FAIL div_stale got=%b exp=000001", {gnt, wb_v, busy}); end
    for (int i = 2; i <= 11; i++) begin
      @(negedge clk); div_done = 1'b0; #1;
      checks++; if ({wb_v, busy} !== 2'b01) begin errors++; $display("FAIL div_wait t+%0d got=%b exp=01", i, {wb_v, busy}); end
    end
    @(negedge clk); div_done = 1'b1; dbz = 1'b1; #1;
    checks++; if (wb_v !== 1'b0) begin errors++; $display("FAIL div_early got=%b exp=0", wb_v); end
    @(negedge clk); div_done = 1'b0; dbz = 1'b0; #1;
    checks++; if ({wb_v, wb_exc, wb_tag, busy} !== {1'b1, 2'b01, 6'h23, 1'b0}) begin errors++; $display("FAIL div_wb got=%h exp=%h", {wb_v, wb_exc, wb_tag, busy}, {1'b1, 2'b01, 6'h23, 1'b0}); end
    checks++; if (wb_res !== 64'hD1D0) begin errors++; $display("FAIL div_res got=%h exp=d1d0", wb_res); end
  endtask

  task automatic test_backpressure();
    @(negedge clk); req = 4'b0001; req_cls[1:0] = 2'b00; alu_fix = 64'h5555; #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL bp_gnt0 got=%b exp=0001", gnt); end
    @(negedge clk); req = 4'b0010; req_cls[3:2] = 2'b00; #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL bp_exec got=%b exp=0000", gnt); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); wb_stall = 1'b1; alu_fix = 64'h1000 + 64'(i); #1;
      checks++; if ({gnt, wb_v, wb_tag, wb_exc} !== {4'b0000, 1'b1, 6'h10, 2'b00}) begin errors++; $display("FAIL bp_hold i=%0d got=%h exp=%h", i, {gnt, wb_v, wb_tag, wb_exc}, {4'b0000, 1'b1, 6'h10, 2'b00}); end
      checks++; if (wb_res !== 64'h5555) begin errors++; $display("FAIL bp_res i=%0d got=%h exp=5555", i, wb_res); end
    end
    @(negedge clk); wb_stall = 1'b0; #1;
    checks++; if ({gnt, wb_v} !== 5'b0010_1) begin errors++; $display("FAIL bp_release got=%b exp=00101", {gnt, wb_v}); end
    @(negedge clk); req = 4'b0000; alu_fix = 64'h7777; #1;
    checks++; if (wb_v !== 1'b0) begin errors++; $display("FAIL bp_clr got=%b exp=0", wb_v); end
    @(negedge clk); #1;
    checks++; if ({wb_v, wb_tag} !== {1'b1, 6'h11}) begin errors++; $display("FAIL bp_new got=%h exp=%h", {wb_v, wb_tag}, {1'b1, 6'h11}); end
    checks++; if (wb_res !== 64'h7777) begin errors++; $display("FAIL bp_newres got=%h exp=7777", wb_res); end
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk); req = 4'b0010; req_cls[3:2] = 2'b10; #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rmd_gnt got=%b exp=0010", gnt); end
    @(negedge clk); req = 4'b0000; #1;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmd_busy got=%b exp=1", busy); end
    @(negedge clk); rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0; div_done = 1'b1; dbz = 1'b1;
    req = 4'b1001; req_cls[7:6] = 2'b00; req_cls[1:0] = 2'b00; #1;
    checks++; if ({busy, wb_v, wb_tag, wb_exc} !== 10'h000) begin errors++; $display("FAIL rmd_clear got=%h exp=000", {busy, wb_v, wb_tag, wb_exc}); end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rmd_ptr got=%b exp=0001", gnt); end
    @(negedge clk); div_done = 1'b0; dbz = 1'b0; req = 4'b0000; #1;
    checks++; if ({wb_v, busy} !== 2'b01) begin errors++; $display("FAIL rmd_late got=%b exp=01", {wb_v, busy}); end
    @(negedge clk); #1;
    checks++; if ({wb_v, wb_tag, wb_exc} !== {1'b1, 6'h10, 2'b00}) begin errors++; $display("FAIL rmd_wb got=%h exp=%h", {wb_v, wb_tag, wb_exc}, {1'b1, 6'h10, 2'b00}); end
  endtask

`ifdef QUPLS_ALU_DIV_TIMEOUT_EN
  task automatic test_div_timeout();
    @(negedge clk); req = 4'b0100; req_cls[5:4] = 2'b10; alu_fix = 64'hFFFF; #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL tmo_gnt got=%b exp=0100", gnt); end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); req = 4'b0000; #1;
      checks++; if (wb_v !== 1'b0) begin errors++; $display("FAIL tmo_wait t+%0d got=%b exp=0", i, wb_v); end
    end
    @(negedge clk); #1;
    checks++; if ({wb_v, wb_exc, wb_tag, busy} !== {1'b1, 2'b10, 6'h15, 1'b0}) begin errors++; $display("FAIL tmo_wb got=%h exp=%h", {wb_v, wb_exc, wb_tag, busy}, {1'b1, 2'b10, 6'h15, 1'b0}); end
    checks++; if (wb_res !== 64'h0) begin errors++; $display("FAIL tmo_res got=%h exp=0", wb_res); end
    @(negedge clk); div_done = 1'b1; #1;
    @(negedge clk); div_done = 1'b0; #1;
    checks++; if ({wb_v, busy} !== 2'b00) begin errors++; $display("FAIL tmo_stray got=%b exp=00", {wb_v, busy}); end
  endtask
`endif

  initial begin
    rst = 1'b1; req = '0; req_cls = '0; req_tag = {6'h13, 6'h12, 6'h11, 6'h10};
    div_done = 1'b0; dbz = 1'b0; wb_stall = 1'b0; alu_fix_en = 1'b0; alu_fix = '0;
    test_reset();
    test_rotation();
    test_mul();
    test_div_stale();
    test_backpressure();
    test_reset_mid_div();
`ifdef QUPLS_ALU_DIV_TIMEOUT_EN
    test_div_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/qupls_alu_issue_ctrl.md
Name: qupls_alu_issue_ctrl

Overview:
- Issue controller for a single ALU lane.
- Arbitrates among NREQ reservation-station requesters using round-robin, and pulses the ALU load strobe.
- Sequences each operation by latency class: single-cycle, fixed-latency multiply, or variable-latency divide. The ALU multiplier is not pipelined across loads because its done counter restarts on every load, so a multiply occupies the lane for MUL_LAT cycles.
- Captures the ALU result and presents it with its tag on a writeback port that supports backpressure.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TAGW, 6, width of the ROB/result tag.
- WID, 64, ALU data width.
- MUL_LAT, 4, cycles from alu_ld to a valid multiply result (the cycle in which mul_done asserts).
- DIV_TMO, 255, divide watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  NREQ  per-requester issue request; held until granted
- req_cls  in  2*NREQ  per-requester class: 00 single, 01 mul, 10 div, 11 treated as single
- req_tag  in  TAGW*NREQ  per-requester result tag
- gnt  out  NREQ  one-hot grant pulse, one cycle
- alu_ld  out  1  ALU load strobe; high in the grant cycle
- alu_sel  out  $clog2(NREQ)  operand-mux select; held from grant until result capture
- alu_o  in  WID  ALU result
- alu_div_done  in  1  divider done
- alu_dbz  in  1  divide by zero
- wb_v  out  1  writeback valid
- wb_tag  out  TAGW  writeback tag
- wb_res  out  WID  writeback data
- wb_exc  out  2  00 none, 01 divide-by-zero, 10 divide timeout
- wb_stall  in  1  writeback sink not ready
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; cycle counter 0.
- Arbitration:
  - Search starts at the pointer and wraps modulo NREQ; the first asserted req wins.
  - After a grant, the pointer becomes winner+1 mod NREQ.
  - Grants are issued only in IDLE, and only when (!wb_v || !wb_stall).
- Grant cycle:
  - gnt[k]=1 and alu_ld=1.
  - alu_sel<=k; the tag and class are latched.
  - Next state follows the class: single→EXEC1, mul→MULW, div→DIVW.
- EXEC1 (one cycle):
  - Capture alu_o into wb_res and the tag into wb_tag; set wb_v=1, wb_exc=00.
  - Return to IDLE. Result latency is 2 cycles from grant to wb_v.
- MULW:
  - Counter counts cycles after alu_ld.
  - When the count reaches MUL_LAT-1, capture alu_o, set wb_v, and go to IDLE.
  - Latency is MUL_LAT+1 cycles from grant to wb_v.
- DIVW:
  - alu_div_done is ignored in the first cycle after alu_ld, because the divider runs on clk2x and its stale done may still be high.
  - From the second cycle on, done=1 captures alu_o, sets wb_exc=01 if alu_dbz, sets wb_v, and goes to IDLE.
- Writeback hold:
  - wb_v, wb_tag, wb_res and wb_exc stay stable while wb_stall=1.
  - wb_v clears the cycle after it is seen with wb_stall=0, unless a new result is captured in that same cycle; the new result then replaces it (back-to-back writeback).
  - No capture may occur while wb_v&&wb_stall. The arbitration gate guarantees this: a capture follows a grant, and no grant is issued while the slot is held.
- Back-to-back: issue may proceed in the same cycle wb_v is consumed, so single-cycle ops achieve one result every 2 cycles.
- Simultaneous requests: exactly one gnt bit is ever high. A requester whose req drops before grant is simply skipped.
- Reset mid-operation: takes effect immediately. Any in-flight op is discarded, wb_v=0, and no late capture occurs even if div_done rises afterward.
- Class 11 is treated as single.
- NREQ=1: the pointer stays 0.

Optional Feature:
- Macro: QUPLS_ALU_DIV_TIMEOUT_EN.
- Enabled:
  - DIVW counts cycles.
  - If the count reaches DIV_TMO without done, the block captures wb_res=0, wb_exc=10, wb_v=1 and returns to IDLE.
  - A later stray alu_div_done is ignored in IDLE.
- Disabled:
  - DIVW waits indefinitely.
  - wb_exc never takes the value 10.
  - DIV_TMO is unused.

Test Plan:
- Single op, fair rotation: req=4'b1111, all class 00, stall=0, pointer 0 → gnt order 0,1,2,3,0 with one grant every 2 cycles; wb_tag follows the tags in the same order; wb_v 2 cycles after each gnt.
- Multiply: req[2] with class 01, tag 6'h15, alu_o=64'h1234 stable → alu_ld at cycle t, wb_v at t+5 with wb_res=64'h1234 and tag 15; no gnt in t+1..t+4 while req[0] is held.
- Divide with stale done: alu_div_done held 1 across the grant cycle and the cycle after, then low for 10 cycles, then pulsed → no capture until the pulse; on the pulse, wb_v with alu_dbz=1 gives wb_exc=01.
- Backpressure: wb_stall=1 for 6 cycles after a single-op result with req[1] pending → wb fields stable, no gnt; stall drops → gnt[1] in the same cycle, new wb_v 2 cycles later.
- Reset mid-divide: assert rst in DIVW, then pulse alu_div_done → wb_v stays 0, busy=0, pointer 0, next grant goes to the lowest asserted req.
- With QUPLS_ALU_DIV_TIMEOUT_EN, DIV_TMO=20, no done → wb_v 21 cycles after alu_ld with wb_exc=10 and wb_res=0.
